time_uart_tx: RTL

Reports the wall-clock time over a UART line: it takes the current hours/minutes/seconds from the clock counters and serialises the 10-character ASCII string "HH:MM:SS\r\n", 8N1, LSB first. It is the transmit end of the clock's UART control path, the counterpart to the command side that reconfigures the counters. A report starts automatically on every seconds change or on an explicit request pulse.

---
 rtl/time_uart_tx_pkg.sv | 52 +++++
 rtl/uart_tx_byte.sv | 58 +++++
 rtl/time_uart_tx.sv | 125 ++++++++++++
 3 files changed

// File: rtl/time_uart_tx_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : time_uart_tx_pkg                                              |
// | Purpose  : ASCII constants, message length, FSM states, digit helpers    |
// | Revision : 1.0                                                           |
// ---------------------------------------------------------------------------
package time_uart_tx_pkg;

   localparam logic [7:0] C_ZERO    = 8'h30;
   localparam logic [7:0] C_COLON   = 8'h3A;
   localparam logic [7:0] C_CR      = 8'h0D;
   localparam logic [7:0] C_LF      = 8'h0A;
   localparam int         C_MSG_LEN = 10;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_FIN  = 2'd3
   } state_t;

   // Tens digit by comparison ladder; a 6-bit input never exceeds 63.
   function automatic logic [3:0] tens_digit(input logic [5:0] v);
      if (v >= 6'd60)      return 4'd6;
      else if (v >= 6'd50) return 4'd5;
      else if (v >= 6'd40) return 4'd4;
      else if (v >= 6'd30) return 4'd3;
      else if (v >= 6'd20) return 4'd2;
      else if (v >= 6'd10) return 4'd1;
      else                 return 4'd0;
   endfunction

   function automatic logic [3:0] units_digit(input logic [5:0] v);
      logic [5:0] base;
      case (tens_digit(v))
         4'd6:    base = 6'd60;
         4'd5:    base = 6'd50;
         4'd4:    base = 6'd40;
         4'd3:    base = 6'd30;
         4'd2:    base = 6'd20;
         4'd1:    base = 6'd10;
         default: base = 6'd0;
      endcase
      return 4'(v - base);
   endfunction

   function automatic logic [7:0] ascii_digit(input logic [3:0] d);
      return C_ZERO + {4'd0, d};
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_byte.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : uart_tx_byte                                                  |
// | Purpose  : 8N1 byte serialiser, LSB first, back-to-back capable          |
// | Revision : 1.0                                                           |
// ---------------------------------------------------------------------------
module uart_tx_byte #(
   parameter int BAUD_DIV = 434
) (
   input  logic       clk,
   input  logic       resett,
   input  logic       start,
   input  logic [7:0] data,
   output logic       tx,
   output logic       ready
);

   localparam int               CNT_W      = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(BAUD_DIV - 1);

   logic             r_active;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_bit_idx;
   logic [9:0]       r_shift;
   logic             w_last;

   // Ready during the final stop-bit cycle so the next start bit follows with no idle gap.
   always_comb begin
      w_last = r_active && (r_bit_idx == 4'd9) && (r_cnt == C_CNT_LAST);
      ready  = !r_active || w_last;
      tx     = r_shift[0];
   end

   always_ff @(posedge clk) begin
      if (resett) begin
         r_active  <= 1'b0;
         r_cnt     <= '0;
         r_bit_idx <= 4'd0;
         r_shift   <= '1;
      end else if (start && ready) begin
         r_active  <= 1'b1;
         r_cnt     <= '0;
         r_bit_idx <= 4'd0;
         r_shift   <= {1'b1, data, 1'b0};
      end else if (r_active) begin
         if (r_cnt == C_CNT_LAST) begin
            r_cnt   <= '0;
            r_shift <= {1'b1, r_shift[9:1]};
            if (r_bit_idx == 4'd9) r_active  <= 1'b0;
            else                   r_bit_idx <= r_bit_idx + 4'd1;
         end else begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/time_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// | Module   : time_uart_tx                                                  |
// | Purpose  : Sends "HH:MM:SS\r\n" over UART on seconds change or request   |
// | Revision : 1.0                                                           |
// ---------------------------------------------------------------------------
module time_uart_tx
   import time_uart_tx_pkg::*;
#(
   parameter int CLK_HZ = 50000000,
   parameter int BAUD   = 115200
) (
   input  logic       clk,
   input  logic       resett,
   input  logic [4:0] hours,
   input  logic [5:0] minutes,
   input  logic [5:0] seconds,
   input  logic       auto_en,
   input  logic       report_req,
   output logic       tx,
   output logic       busy,
   output logic       done
);

   localparam int BAUD_DIV = CLK_HZ / BAUD;

   state_t     r_state, w_state_next;
   logic       r_pending;
   logic [5:0] r_prev_sec;
   logic [4:0] r_hours;
   logic [5:0] r_minutes, r_seconds;
   logic [3:0] r_char_idx;
   logic       w_trigger, w_start, w_ready;
   logic [3:0] w_sel;
   logic [5:0] w_h, w_m, w_s;
   logic [7:0] w_char;

   always_comb w_trigger = report_req | (auto_en & (seconds != r_prev_sec));

   always_comb begin
      w_state_next = r_state;
      w_start      = 1'b0;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         ST_IDLE: if (w_trigger || r_pending) w_state_next = ST_LOAD;
         ST_LOAD: begin
            busy         = 1'b1;
            w_start      = 1'b1;
            w_state_next = ST_SEND;
         end
         ST_SEND: begin
            busy = 1'b1;
            if (w_ready) begin
               if (r_char_idx == 4'(C_MSG_LEN)) w_state_next = ST_FIN;
               else                             w_start      = 1'b1;
            end
         end
         ST_FIN: begin
            done         = 1'b1;
            w_state_next = (w_trigger || r_pending) ? ST_LOAD : ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   // Char 0 leaves during LOAD, before the snapshot registers hold the new values.
   always_comb begin
      w_sel  = (r_state == ST_LOAD) ? 4'd0 : r_char_idx;
      w_h    = (r_state == ST_LOAD) ? {1'b0, hours} : {1'b0, r_hours};
      w_m    = (r_state == ST_LOAD) ? minutes : r_minutes;
      w_s    = (r_state == ST_LOAD) ? seconds : r_seconds;
      w_char = C_LF;
      case (w_sel)
         4'd0:    w_char = ascii_digit(tens_digit(w_h));
         4'd1:    w_char = ascii_digit(units_digit(w_h));
         4'd2:    w_char = C_COLON;
         4'd3:    w_char = ascii_digit(tens_digit(w_m));
         4'd4:    w_char = ascii_digit(units_digit(w_m));
         4'd5:    w_char = C_COLON;
         4'd6:    w_char = ascii_digit(tens_digit(w_s));
         4'd7:    w_char = ascii_digit(units_digit(w_s));
         4'd8:    w_char = C_CR;
         default: w_char = C_LF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (resett) begin
         r_state    <= ST_IDLE;
         r_pending  <= 1'b0;
         r_prev_sec <= seconds;
         r_char_idx <= 4'd0;
         r_hours    <= '0;
         r_minutes  <= '0;
         r_seconds  <= '0;
      end else begin
         r_state    <= w_state_next;
         r_prev_sec <= seconds;
         if (w_state_next == ST_LOAD && r_state != ST_LOAD) r_pending <= 1'b0;
         else if (w_trigger && r_state != ST_IDLE)          r_pending <= 1'b1;
         if (r_state == ST_LOAD) begin
            r_hours    <= hours;
            r_minutes  <= minutes;
            r_seconds  <= seconds;
            r_char_idx <= 4'd1;
         end else if (w_start) begin
            r_char_idx <= r_char_idx + 4'd1;
         end
      end
   end

   uart_tx_byte #(
      .BAUD_DIV (BAUD_DIV)
   ) u_byte (
      .clk    (clk),
      .resett (resett),
      .start  (w_start),
      .data   (w_char),
      .tx     (tx),
      .ready  (w_ready)
   );

endmodule
`default_nettype wire
